// File: rtl/gray_frame_arbiter_pkg.sv
// Shared types for the grayscale frame arbiter: FSM states, the pixel
// framing bundle and the frame-size helper.
package gray_arb_pkg;

    // Width of the data field carried in pix_if_t (one RGB888 pixel).
    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        STREAM   = 2'd2
    } arb_state_t;

    // One beat of the val/sof/eof/sol/eol/data pixel stream.
    typedef struct packed {
        logic             val;
        logic             sof;
        logic             eof;
        logic             sol;
        logic             eol;
        logic [PIX_W-1:0] data;
    } pix_if_t;

    // Number of pixels in one complete frame.
    function automatic int FRAME_PIXELS(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/gray_frame_arbiter_rr_arb2.sv
// Two-requester round-robin picker. The pointer holds the index of the
// source that finished last; contention goes to the other one.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd_en,
    input  logic       upd_idx,
    output logic       pick
);

    logic last_q;

    // Last-grant pointer; reset to 1 so source 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (upd_en) begin
            last_q <= upd_idx;
        end
    end

    // Combinational pick from the current requests and pointer.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no
        // latch is inferred.
        pick = 1'b0;
        unique case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_q;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/gray_frame_arbiter.sv
// Frame-granular arbiter sharing the RGB-to-grayscale stage between two
// pixel sources. Ownership changes only between frames; every m_* output
// is registered (one cycle latency from the granted source).
// Optional build macro GRAY_ARB_TIMEOUT_EN: abandons a grant that has not
// produced sof within TIMEOUT_CYCLES cycles.
module gray_frame_arbiter
    import gray_arb_pkg::*;
#(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int PIX_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 s0_req,
    input  logic                 s0_val,
    input  logic                 s0_sof,
    input  logic                 s0_eof,
    input  logic                 s0_sol,
    input  logic                 s0_eol,
    input  logic [PIX_WIDTH-1:0] s0_data,
    output logic                 s0_gnt,

    input  logic                 s1_req,
    input  logic                 s1_val,
    input  logic                 s1_sof,
    input  logic                 s1_eof,
    input  logic                 s1_sol,
    input  logic                 s1_eol,
    input  logic [PIX_WIDTH-1:0] s1_data,
    output logic                 s1_gnt,

    output logic                 m_val,
    output logic                 m_sof,
    output logic                 m_eof,
    output logic                 m_sol,
    output logic                 m_eol,
    output logic [PIX_WIDTH-1:0] m_data,
    output logic                 m_sel,
    output logic                 busy,
    output logic                 frame_err
);

    // PIX_WIDTH is expected to match the package data field (RGB888).
    localparam int N_PIX = FRAME_PIXELS(FRAME_WIDTH, FRAME_HEIGHT);
    localparam int CNT_W = $clog2(N_PIX + 1);

    arb_state_t       state_q, state_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    pix_if_t          s0_pix, s1_pix, cur_pix;
    pix_if_t          m_q, m_d;
    logic             err_q, err_d;
    logic             take;
    logic             at_full;
    logic             rr_pick;
    logic             rr_upd;
    logic             wait_done;

    assign s0_pix  = {s0_val, s0_sof, s0_eof, s0_sol, s0_eol, PIX_W'(s0_data)};
    assign s1_pix  = {s1_val, s1_sof, s1_eof, s1_sol, s1_eol, PIX_W'(s1_data)};
    // Only the owning source is ever looked at; the other is ignored.
    assign cur_pix = sel_q ? s1_pix : s0_pix;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({s1_req, s0_req}),
        .upd_en  (rr_upd),
        .upd_idx (sel_q),
        .pick    (rr_pick)
    );

`ifdef GRAY_ARB_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WAIT_W-1:0] wait_q;

    // Cycles spent in WAIT_SOF for the current grant; cleared elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (state_q == WAIT_SOF) begin
            wait_q <= wait_q + WAIT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end

    // High on the last permitted WAIT_SOF cycle.
    assign wait_done = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
    assign wait_done = 1'b0;
`endif

    // Next-state, counter and output-beat logic for the grant FSM.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        m_d     = '0;
        err_d   = 1'b0;
        rr_upd  = 1'b0;
        take    = 1'b0;
        cnt_inc = cur_pix.sof ? CNT_W'(1) : cnt_q + CNT_W'(1);
        at_full = (cnt_inc == CNT_W'(N_PIX));

        unique case (state_q)
            IDLE: begin
                if (s0_req || s1_req) begin
                    sel_d   = rr_pick;
                    state_d = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                // Anything before the first sof is dropped.
                take = cur_pix.val && cur_pix.sof;
                if (!take && wait_done) begin
                    err_d   = 1'b1;
                    rr_upd  = 1'b1;
                    state_d = IDLE;
                end
            end
            STREAM: begin
                take = cur_pix.val;
                // A fresh sof mid-frame restarts the frame and is flagged.
                err_d = cur_pix.val && cur_pix.sof;
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            m_d     = cur_pix;
            cnt_d   = cnt_inc;
            state_d = STREAM;
            // eof must coincide exactly with the last pixel of the frame.
            if (cur_pix.eof != at_full) begin
                err_d = 1'b1;
            end
            if (cur_pix.eof || at_full) begin
                m_d.eof = 1'b1;
                rr_upd  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // FSM, owner index and pixel counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output beat and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data register is reset along with the strobes so the
        // whole master port reads zero out of reset, not just m_val.
        if (!rst_n) begin
            m_q   <= '0;
            err_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            err_q <= err_d;
        end
    end

    assign m_val     = m_q.val;
    assign m_sof     = m_q.sof;
    assign m_eof     = m_q.eof;
    assign m_sol     = m_q.sol;
    assign m_eol     = m_q.eol;
    assign m_data    = PIX_WIDTH'(m_q.data);
    assign m_sel     = sel_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);
    assign s0_gnt    = busy && !sel_q;
    assign s1_gnt    = busy && sel_q;

endmodule

// File: tb/tb_gray_frame_arbiter.sv
// Self-checking bench for gray_frame_arbiter on a 4x2 frame. Directed
// scenarios followed by randomized traffic, all compared every cycle with a
// behavioural model. Build with GRAY_ARB_TIMEOUT_EN to add the timeout case.
module tb_gray_frame_arbiter;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s0_req, s0_val, s0_sof, s0_eof, s0_sol, s0_eol;
    logic [23:0] s0_data;
    logic        s1_req, s1_val, s1_sof, s1_eof, s1_sol, s1_eol;
    logic [23:0] s1_data;
    logic        s0_gnt, s1_gnt;
    logic        m_val, m_sof, m_eof, m_sol, m_eol, m_sel, busy, frame_err;
    logic [23:0] m_data;

    gray_frame_arbiter #(
        .FRAME_WIDTH    (W),
        .FRAME_HEIGHT   (H),
        .PIX_WIDTH      (24),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_req    (s0_req),
        .s0_val    (s0_val),
        .s0_sof    (s0_sof),
        .s0_eof    (s0_eof),
        .s0_sol    (s0_sol),
        .s0_eol    (s0_eol),
        .s0_data   (s0_data),
        .s0_gnt    (s0_gnt),
        .s1_req    (s1_req),
        .s1_val    (s1_val),
        .s1_sof    (s1_sof),
        .s1_eof    (s1_eof),
        .s1_sol    (s1_sol),
        .s1_eol    (s1_eol),
        .s1_data   (s1_data),
        .s1_gnt    (s1_gnt),
        .m_val     (m_val),
        .m_sof     (m_sof),
        .m_eof     (m_eof),
        .m_sol     (m_sol),
        .m_eol     (m_eol),
        .m_data    (m_data),
        .m_sel     (m_sel),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        val;
        logic        sof;
        logic        eof;
        logic        sol;
        logic        eol;
        logic [23:0] data;
    } beat_t;

    // Pending beats per source; popped only while that source owns the port.
    beat_t q0[$];
    beat_t q1[$];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: who owns the port, whether its frame has started,
    // pixels counted so far, who finished last, and the expected outputs.
    int    own;
    bit    in_frame;
    int    cnt;
    bit    last_w;
    bit    sel_m;
    beat_t e_pix;
    bit    e_err;
`ifdef GRAY_ARB_TIMEOUT_EN
    int    wait_n;
`endif

    bit req_jitter;

    // Observation counters taken from the DUT outputs.
    int n_mval, n_meof, n_errp, n_err_misalign, n_g0;
    bit sof_sel[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] dut_ctl();
        return {s0_gnt, s1_gnt, busy, m_sel, m_val, m_sof, m_eof, m_sol, m_eol, frame_err};
    endfunction

    function automatic void model_reset();
        own      = -1;
        in_frame = 1'b0;
        cnt      = 0;
        last_w   = 1'b1;
        sel_m    = 1'b0;
        e_pix    = '0;
        e_err    = 1'b0;
`ifdef GRAY_ARB_TIMEOUT_EN
        wait_n   = 0;
`endif
    endfunction

    // Advance the model by one clock given this cycle's inputs.
    function automatic void model_step(input bit r0, input bit r1, input beat_t p0, input beat_t p1);
        beat_t p;
        e_pix = '0;
        e_err = 1'b0;
        if (own < 0) begin
            if (r0 || r1) begin
                if (r0 && r1) own = (last_w == 1'b0) ? 1 : 0;
                else          own = r0 ? 0 : 1;
                sel_m    = (own == 1);
                in_frame = 1'b0;
                cnt      = 0;
`ifdef GRAY_ARB_TIMEOUT_EN
                wait_n   = 0;
`endif
            end
        end else begin
            p = (own == 0) ? p0 : p1;
            if (p.val && (in_frame || p.sof)) begin
                if (in_frame && p.sof) e_err = 1'b1;
                cnt      = p.sof ? 1 : cnt + 1;
                in_frame = 1'b1;
                e_pix    = p;
                if (p.eof != (cnt == NPIX)) e_err = 1'b1;
                if (p.eof || cnt == NPIX) begin
                    e_pix.eof = 1'b1;
                    last_w    = (own == 1);
                    own       = -1;
                end
            end else if (!in_frame) begin
`ifdef GRAY_ARB_TIMEOUT_EN
                wait_n++;
                if (wait_n == TMO) begin
                    e_err  = 1'b1;
                    last_w = (own == 1);
                    own    = -1;
                end
`endif
            end
        end
    endfunction

    function automatic beat_t junk_beat();
        beat_t b;
        b.val  = 1'($urandom_range(0, 1));
        b.sof  = 1'($urandom_range(0, 1));
        b.eof  = 1'($urandom_range(0, 1));
        b.sol  = 1'($urandom_range(0, 1));
        b.eol  = 1'($urandom_range(0, 1));
        b.data = 24'($urandom);
        return b;
    endfunction

    function automatic beat_t next_beat(input int src);
        beat_t b;
        if (own == src) begin
            if (src == 0 && q0.size() > 0) return q0.pop_front();
            if (src == 1 && q1.size() > 0) return q1.pop_front();
            b      = '0;
            b.data = 24'($urandom);
            return b;
        end
        return junk_beat();
    endfunction

    // Queue a frame: junk lead-in beats, npix pixels (sof on 0 and sof2_at,
    // eof on eof_at, -1 for none) with optional idle gaps.
    task automatic push_frame(input int src, input int npix, input int eof_at,
                              input int sof2_at, input int junk, input int gap_pct);
        beat_t f[$];
        beat_t b;
        int    k;
        for (int j = 0; j < junk; j++) begin
            b      = '0;
            b.val  = 1'b1;
            b.data = 24'($urandom);
            f.push_back(b);
        end
        k = 0;
        for (int i = 0; i < npix; i++) begin
            if (i == sof2_at) k = 0;
            while ($urandom_range(0, 99) < gap_pct) begin
                b      = '0;
                b.data = 24'($urandom);
                f.push_back(b);
            end
            b.val  = 1'b1;
            b.sof  = (i == 0) || (i == sof2_at);
            b.eof  = (i == eof_at);
            b.sol  = (k % W == 0);
            b.eol  = (k % W == W - 1);
            b.data = 24'($urandom);
            f.push_back(b);
            k++;
        end
        foreach (f[i]) begin
            if (src == 0) q0.push_back(f[i]);
            else          q1.push_back(f[i]);
        end
    endtask

    task automatic push_random(input int src);
        int kind;
        int e;
        kind = $urandom_range(0, 9);
        case (kind)
            5:       begin e = $urandom_range(0, NPIX - 2); push_frame(src, e + 1, e, -1, 0, 20); end
            6:       push_frame(src, $urandom_range(NPIX, NPIX + 3), -1, -1, 0, 20);
            7:       begin e = $urandom_range(1, NPIX - 2); push_frame(src, e + NPIX, e + NPIX - 1, e, 0, 20); end
            8:       push_frame(src, NPIX, NPIX - 1, -1, $urandom_range(1, 3), 20);
            9:       push_frame(src, NPIX, -1, -1, 0, 20);
            default: push_frame(src, NPIX, NPIX - 1, -1, 0, 20);
        endcase
    endtask

    task automatic observe();
        check_val("ctl", 64'(dut_ctl()),
                  64'({own == 0, own == 1, own >= 0, sel_m, e_pix.val, e_pix.sof,
                       e_pix.eof, e_pix.sol, e_pix.eol, e_err}));
        check_val("data", 64'(m_data), 64'(e_pix.data));
        n_mval += int'(m_val);
        n_meof += int'(m_val && m_eof);
        n_errp += int'(frame_err);
        n_err_misalign += int'(frame_err && !m_eof);
        n_g0   += int'(s0_gnt);
        if (m_val && m_sof) sof_sel.push_back(m_sel);
    endtask

    task automatic clear_mon();
        n_mval = 0; n_meof = 0; n_errp = 0; n_err_misalign = 0; n_g0 = 0;
        sof_sel.delete();
    endtask

    task automatic drive_idle();
        {s0_req, s0_val, s0_sof, s0_eof, s0_sol, s0_eol, s0_data} = '0;
        {s1_req, s1_val, s1_sof, s1_eof, s1_sol, s1_eol, s1_data} = '0;
    endtask

    // One clock: check outputs on the falling edge, then apply new inputs.
    task automatic cycle();
        bit    r0, r1;
        beat_t b0, b1;
        @(negedge clk);
        observe();
        r0 = (q0.size() > 0) && !(req_jitter && $urandom_range(0, 7) == 0);
        r1 = (q1.size() > 0) && !(req_jitter && $urandom_range(0, 7) == 0);
        b0 = next_beat(0);
        b1 = next_beat(1);
        s0_req = r0;
        {s0_val, s0_sof, s0_eof, s0_sol, s0_eol, s0_data} = b0;
        s1_req = r1;
        {s1_val, s1_sof, s1_eof, s1_sol, s1_eol, s1_data} = b1;
        model_step(r0, r1, b0, b1);
    endtask

    task automatic run_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            cycle();
            if (own < 0 && q0.size() == 0 && q1.size() == 0) break;
        end
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        q0.delete();
        q1.delete();
        model_reset();
        #1;
        check_val("rst_ctl", 64'(dut_ctl()), 64'd0);
        check_val("rst_data", 64'(m_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive_idle();
        model_reset();
        clear_mon();
        req_jitter = 1'b0;
        do_reset();

        // Single clean frame from source 0.
        clear_mon();
        push_frame(0, NPIX, NPIX - 1, -1, 0, 0);
        run_idle(40);
        check_val("t1_pixels", 64'(n_mval), 64'(NPIX));
        check_val("t1_eof", 64'(n_meof), 64'd1);
        check_val("t1_err", 64'(n_errp), 64'd0);

        // Contention: two frames queued on each source.
        do_reset();
        clear_mon();
        for (int f = 0; f < 2; f++) begin
            push_frame(0, NPIX, NPIX - 1, -1, 0, 0);
            push_frame(1, NPIX, NPIX - 1, -1, 0, 0);
        end
        run_idle(200);
        check_val("t2_frames", 64'(sof_sel.size()), 64'd4);
        for (int i = 0; i < sof_sel.size() && i < 4; i++) begin
            check_val("t2_sel", 64'(sof_sel[i]), 64'(i % 2));
        end

        // Short frame: eof on the sixth pixel.
        do_reset();
        clear_mon();
        push_frame(0, 6, 5, -1, 0, 0);
        run_idle(40);
        check_val("t3_pixels", 64'(n_mval), 64'd6);
        check_val("t3_eof", 64'(n_meof), 64'd1);
        check_val("t3_err", 64'(n_errp), 64'd1);
        check_val("t3_align", 64'(n_err_misalign), 64'd0);

        // Missing eof: ten pixels, the last two must be dropped.
        do_reset();
        clear_mon();
        push_frame(0, NPIX + 2, -1, -1, 0, 0);
        repeat (20) cycle();
        check_val("t4_pixels", 64'(n_mval), 64'(NPIX));
        check_val("t4_eof", 64'(n_meof), 64'd1);
        check_val("t4_err", 64'(n_errp), 64'd1);
        check_val("t4_align", 64'(n_err_misalign), 64'd0);

        // Pre-sof junk, then an asynchronous reset part-way through.
        do_reset();
        clear_mon();
        push_frame(0, NPIX, NPIX - 1, -1, 3, 0);
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (n_mval >= 4) break;
        end
        check_val("t5_reach", 64'(n_mval), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_gnt", 64'(s0_gnt), 64'd0);
        check_val("t5_mval", 64'(m_val), 64'd0);
        check_val("t5_busy", 64'(busy), 64'd0);
        do_reset();

`ifdef GRAY_ARB_TIMEOUT_EN
        // Source 0 never sends sof; source 1 has a frame waiting.
        do_reset();
        clear_mon();
        push_frame(0, 0, -1, -1, 12, 0);
        push_frame(1, NPIX, NPIX - 1, -1, 0, 0);
        run_idle(80);
        check_val("t6_gnt0_cycles", 64'(n_g0), 64'(TMO));
        check_val("t6_err", 64'(n_errp), 64'd1);
        check_val("t6_frames", 64'(sof_sel.size()), 64'd1);
        if (sof_sel.size() > 0) check_val("t6_sel", 64'(sof_sel[0]), 64'd1);
`endif

        // Randomized traffic with malformed frames and req jitter.
        do_reset();
        clear_mon();
        req_jitter = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 15) == 0) push_random(0);
            if (q1.size() == 0 && $urandom_range(0, 15) == 0) push_random(1);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
